// File: rtl/pam4_tx_upsampler.sv
// 4-ASK (Gray) transmit symbol source: symbol FIFO, level mapper and OS-times upsampler.
// Ports: sys_clk/reset, sam_clk_en/sym_clk_en strobes, in_sym/in_valid/in_ready input
//   handshake, clr_flags, tx_out (1s17) + tx_sym_strobe, fill, sticky underflow/align_err.
module pam4_tx_upsampler #(
    parameter int                 DEPTH      = 4,
    parameter int                 OS         = 4,
    parameter logic signed [17:0] LVL_A      = 18'sd32768,
    parameter int                 ZERO_STUFF = 1
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       sam_clk_en,
    input  logic                       sym_clk_en,
    input  logic [1:0]                 in_sym,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clr_flags,
    output logic signed [17:0]         tx_out,
    output logic                       tx_sym_strobe,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       underflow,
    output logic                       align_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int PW = (OS > 1) ? $clog2(OS) : 1;
    localparam logic signed [17:0] LVL_3A = 18'(3 * LVL_A);

    if ((3 * LVL_A) > 131071 || LVL_A < 0) begin : g_bad_level
        $error("pam4_tx_upsampler: 3*LVL_A must lie in 0..131071");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pam4_tx_upsampler: DEPTH must be a power of 2, >= 2");
    end
    if (OS < 1) begin : g_bad_os
        $error("pam4_tx_upsampler: OS must be >= 1");
    end

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] phase;

    logic strobe;
    logic sam_only;
    logic push;
    logic pop;
    logic uf_set;
    logic ae_set;

    function automatic logic signed [17:0] map_sym(input logic [1:0] s);
        case (s)
            2'b00:   map_sym = -LVL_3A;
            2'b01:   map_sym = -LVL_A;
            2'b11:   map_sym = LVL_A;
            default: map_sym = LVL_3A;
        endcase
    endfunction

    assign strobe   = sam_clk_en && sym_clk_en;
    assign sam_only = sam_clk_en && !sym_clk_en;
    assign in_ready = (fill < FW'(DEPTH));
    assign push     = in_valid && in_ready;
    // A same-edge push is not yet in fill, so it can never feed this pop.
    assign pop      = strobe && (fill != '0);
    assign uf_set   = strobe && (fill == '0);
    assign ae_set   = (strobe && (phase != '0)) || (sam_only && (phase == '0));

    // Storage needs no reset: pointers and fill define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sym;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fill <= fill + FW'(push) - FW'(pop);
        end
    end

    // Phase always resyncs to the strobe, even when the strobe itself was misaligned.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (strobe) begin
            phase <= (OS == 1) ? '0 : PW'(1);
        end else if (sam_clk_en) begin
            phase <= (phase == PW'(OS - 1)) ? '0 : phase + PW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx_out        <= '0;
            tx_sym_strobe <= 1'b0;
        end else begin
            tx_sym_strobe <= strobe;
            if (strobe) begin
                tx_out <= pop ? map_sym(mem[rd_ptr]) : '0;
            end else if (sam_clk_en && (ZERO_STUFF != 0)) begin
                tx_out <= '0;
            end
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (uf_set) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
            if (ae_set) begin
                align_err <= 1'b1;
            end else if (clr_flags) begin
                align_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pam4_tx_upsampler.sv
// Scoreboard bench for pam4_tx_upsampler: zero-stuff and hold-mode instances share stimulus.
// Ports: none; drives both DUTs and prints a one-line summary.
module tb_pam4_tx_upsampler;

    localparam int DEPTH = 4;
    localparam int OS    = 4;
    localparam logic signed [17:0] A1 = 18'sd32768;
    localparam logic signed [17:0] A3 = 18'sd98304;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sam_en = 1'b0;
    logic sym_en_s = 1'b0;
    logic [1:0] in_sym = 2'b00;
    logic in_valid = 1'b0;
    logic clr = 1'b0;

    logic rdy_a, rdy_b, stb_a, stb_b, uf_a, uf_b, ae_a, ae_b;
    logic signed [17:0] tx_a, tx_b;
    logic [2:0] fill_a, fill_b;

    always #5 clk = ~clk;

    pam4_tx_upsampler #(.DEPTH(DEPTH), .OS(OS), .LVL_A(A1), .ZERO_STUFF(1)) ua (
        .sys_clk(clk), .reset(rst_n), .sam_clk_en(sam_en), .sym_clk_en(sym_en_s),
        .in_sym(in_sym), .in_valid(in_valid), .in_ready(rdy_a), .clr_flags(clr),
        .tx_out(tx_a), .tx_sym_strobe(stb_a), .fill(fill_a),
        .underflow(uf_a), .align_err(ae_a)
    );

    pam4_tx_upsampler #(.DEPTH(DEPTH), .OS(OS), .LVL_A(A1), .ZERO_STUFF(0)) ub (
        .sys_clk(clk), .reset(rst_n), .sam_clk_en(sam_en), .sym_clk_en(sym_en_s),
        .in_sym(in_sym), .in_valid(in_valid), .in_ready(rdy_b), .clr_flags(clr),
        .tx_out(tx_b), .tx_sym_strobe(stb_b), .fill(fill_b),
        .underflow(uf_b), .align_err(ae_b)
    );

    typedef struct packed {
        logic signed [17:0] v;
        logic               s;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   mon_b = 1'b0;
    bit   sam_seen = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) sam_seen <= sam_en;

    always @(negedge clk) begin
        exp_t e;
        if (sam_seen) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_a: sample with empty scoreboard at %0t", $time);
            end else begin
                e = qa.pop_front();
                chk("tx_out_a", tx_a, e.v);
                chk("sym_strobe_a", {31'd0, stb_a}, {31'd0, e.s});
            end
            if (mon_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_b: sample with empty scoreboard at %0t", $time);
                end else begin
                    e = qb.pop_front();
                    chk("tx_out_b", tx_b, e.v);
                    chk("sym_strobe_b", {31'd0, stb_b}, {31'd0, e.s});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s);
        in_valid = 1'b1;
        in_sym   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sam(input bit se, input logic signed [17:0] ea, input bit es,
                       input logic signed [17:0] eb);
        sam_en   = 1'b1;
        sym_en_s = se;
        qa.push_back('{v: ea, s: es});
        if (mon_b) qb.push_back('{v: eb, s: es});
        tick();
        sam_en   = 1'b0;
        sym_en_s = 1'b0;
    endtask

    task automatic zeros3();
        for (int i = 0; i < 3; i++) sam(1'b0, 18'sd0, 1'b0, 18'sd0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] burst [6];
        burst = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_out", tx_a, 0);
        chk("rst_fill", {29'd0, fill_a}, 0);
        chk("rst_strobe", {31'd0, stb_a}, 0);
        chk("rst_underflow", {31'd0, uf_a}, 0);
        chk("rst_align", {31'd0, ae_a}, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, rdy_a}, 1);

        // 1: Gray mapping with aligned strobes
        push(2'b00); push(2'b01); push(2'b11); push(2'b10);
        sam(1'b1, -A3, 1'b1, 18'sd0); zeros3();
        sam(1'b1, -A1, 1'b1, 18'sd0); zeros3();
        sam(1'b1,  A1, 1'b1, 18'sd0); zeros3();
        sam(1'b1,  A3, 1'b1, 18'sd0); zeros3();
        chk("t1_fill", {29'd0, fill_a}, 0);
        chk("t1_align", {31'd0, ae_a}, 0);

        // 2: FIFO fills to DEPTH under back-pressure
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_sym = burst[i];
            tick();
        end
        in_valid = 1'b0;
        chk("t2_fill_full", {29'd0, fill_a}, 4);
        chk("t2_ready_full", {31'd0, rdy_a}, 0);
        sam(1'b1, A3, 1'b1, 18'sd0);
        chk("t2_fill_pop", {29'd0, fill_a}, 3);
        chk("t2_ready_pop", {31'd0, rdy_a}, 1);
        zeros3();
        sam(1'b1,  A1, 1'b1, 18'sd0); zeros3();
        sam(1'b1, -A1, 1'b1, 18'sd0); zeros3();
        sam(1'b1, -A3, 1'b1, 18'sd0); zeros3();
        chk("t2_underflow", {31'd0, uf_a}, 0);

        // 3: underflow is sticky until cleared
        sam(1'b1, 18'sd0, 1'b1, 18'sd0);
        chk("t3_underflow", {31'd0, uf_a}, 1);
        zeros3();
        push(2'b01);
        chk("t3_uf_sticky", {31'd0, uf_a}, 1);
        pulse_clr();
        chk("t3_uf_clr", {31'd0, uf_a}, 0);
        sam(1'b1, -A1, 1'b1, 18'sd0); zeros3();

        // 4: same-edge push and strobe on empty FIFO; set beats clear
        in_valid = 1'b1;
        in_sym   = 2'b11;
        clr      = 1'b1;
        sam(1'b1, 18'sd0, 1'b1, 18'sd0);
        in_valid = 1'b0;
        clr      = 1'b0;
        chk("t4_underflow", {31'd0, uf_a}, 1);
        chk("t4_fill", {29'd0, fill_a}, 1);
        zeros3();
        sam(1'b1, A1, 1'b1, 18'sd0); zeros3();
        pulse_clr();

        // 5: strobe at phase 2 flags misalignment and resyncs
        push(2'b00); push(2'b10); push(2'b01);
        sam(1'b1, -A3, 1'b1, 18'sd0);
        sam(1'b0, 18'sd0, 1'b0, 18'sd0);
        chk("t5_align_pre", {31'd0, ae_a}, 0);
        sam(1'b1, A3, 1'b1, 18'sd0);
        chk("t5_align_set", {31'd0, ae_a}, 1);
        zeros3();
        sam(1'b1, -A1, 1'b1, 18'sd0); zeros3();
        chk("t5_align_sticky", {31'd0, ae_a}, 1);
        pulse_clr();
        chk("t5_align_clr", {31'd0, ae_a}, 0);

        // 6: hold mode and asynchronous reset mid-run
        mon_b = 1'b1;
        push(2'b10);
        sam(1'b1, A3, 1'b1, A3);
        for (int i = 0; i < 3; i++) sam(1'b0, 18'sd0, 1'b0, A3);
        push(2'b11);
        sam(1'b1, A1, 1'b1, A1);
        sam(1'b0, 18'sd0, 1'b0, A1);
        push(2'b01);
        chk("t6_fill_pre", {29'd0, fill_b}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_b", tx_b, 0);
        chk("t6_rst_fill_b", {29'd0, fill_b}, 0);
        chk("t6_rst_fill_a", {29'd0, fill_a}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_ready", {31'd0, rdy_b}, 1);
        sam(1'b1, 18'sd0, 1'b1, 18'sd0);
        chk("t6_discard_uf", {31'd0, uf_b}, 1);

        tick();
        tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
